// File: rtl/s2p_pkg.sv
// Shared definitions for the serial framer pair: receiver FSM states,
// idle line level and the even-parity check helper.
package s2p_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } s2p_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Even parity: XOR of all data bits and the parity bit must be 0.
    // Returns 1 when the frame fails the check.
    function automatic logic parity_error(input logic data_xor, input logic parity_bit);
        return data_xor ^ parity_bit;
    endfunction

endpackage

// File: rtl/serial_to_parallel_sipo_shift.sv
// WIDTH-bit shift-in register: new bit enters at the MSB and moves right,
// so the first bit shifted in ends at bit 0 after WIDTH shifts.
module sipo_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic             xor_out
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;

    generate
        if (WIDTH == 1) begin : g_one
            // Single-bit register simply reloads the incoming bit.
            always_comb begin
                q_next_s = din;
            end
        end else begin : g_multi
            // Right shift with the incoming bit entering at the MSB.
            always_comb begin
                q_next_s = {din, q_r[WIDTH-1:1]};
            end
        end
    endgenerate

    // Shift register state, advanced only when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= q_next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q       = q_r;
    assign xor_out = ^q_r;

endmodule

// File: rtl/serial_to_parallel.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, even parity,
// stop bit. Bit timing is given by the bit_en strobe; outputs are registered
// and held between valid pulses.
import s2p_pkg::*;

module serial_to_parallel #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    s2p_state_t       state_r;
    s2p_state_t       state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             shift_en_s;
    logic             sin_q_r;
    logic             perr_r;
    logic [WIDTH-1:0] shift_q_s;
    logic             shift_xor_s;
    logic [WIDTH-1:0] dout_r;
    logic             valid_r;
    logic             parity_err_r;
    logic             frame_err_r;
    logic             busy_r;

    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en_s),
        .din     (sin_q_r),
        .q       (shift_q_s),
        .xor_out (shift_xor_s)
    );

    // Input register: the FSM only ever looks at the registered line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_q_r <= LINE_IDLE;
        end else begin
            sin_q_r <= sin;
        end
    end

    // Next-state, shift enable and counter update; everything holds without a strobe.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        shift_en_s   = 1'b0;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (sin_q_r != LINE_IDLE) begin
                        state_next_s = DATA;
                        cnt_next_s   = '0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DATA: begin
                    shift_en_s = 1'b1;
                    cnt_next_s = cnt_r + CW'(1'b1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_next_s = PARITY;
                    end else begin
                        state_next_s = DATA;
                    end
                end
                PARITY: begin
                    state_next_s = STOP;
                end
                STOP: begin
                    if (sin_q_r == LINE_IDLE) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = BREAK;
                    end
                end
                BREAK: begin
                    if (sin_q_r == LINE_IDLE) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = BREAK;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, bit counter and busy flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Parity capture and output registers; valid is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_r       <= 1'b0;
            dout_r       <= '0;
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (bit_en && (state_r == PARITY)) begin
                perr_r <= parity_error(shift_xor_s, sin_q_r);
            end
            if (bit_en && (state_r == STOP)) begin
                dout_r       <= shift_q_s;
                parity_err_r <= perr_r;
                frame_err_r  <= ~sin_q_r;
                valid_r      <= 1'b1;
            end
        end
    end

    assign dout       = dout_r;
    assign valid      = valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (WIDTH=4). Expected words and flags
// are queued as frames are driven and checked when valid pulses.
module tb_serial_to_parallel;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         sin;
    logic [W-1:0] dout;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int start_cyc;
    int s1;

    logic [W+1:0] sb[$];
    int           vcyc[$];

    logic en_edge    = 1'b0;
    logic busy_prev  = 1'b0;
    logic valid_prev = 1'b0;
    logic rst_prev   = 1'b1;

    serial_to_parallel #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sin        (sin),
        .dout       (dout),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_edge <= bit_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard compare on valid, pulse width, strobe-only state changes.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst && !rst_prev) begin
            if (valid === 1'b1) begin
                vcyc.push_back(cyc);
                chk("unexpected_valid", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("dout", {28'd0, dout}, {28'd0, e[W-1:0]});
                    chk("parity_err", {31'd0, parity_err}, {31'd0, e[W]});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e[W+1]});
                end
            end
            if (valid_prev === 1'b1) chk("valid_width", {31'd0, valid}, 32'd0);
            if (busy !== busy_prev) chk("busy_on_strobe", {31'd0, en_edge}, 32'd1);
        end
        valid_prev = valid;
        busy_prev  = busy;
        rst_prev   = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int hold);
        for (int j = 0; j < hold; j++) begin
            sin    = b;
            bit_en = (j == hold - 1);
            tick();
        end
    endtask

    task automatic idle(input int n);
        sin    = 1'b1;
        bit_en = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic stopb, input int hold);
        logic [W+1:0] e;
        e = {~stopb, (^d) ^ pbit, d};
        sb.push_back(e);
        start_cyc = cyc;
        send_bit(1'b0, hold);
        for (int i = 0; i < W; i++) send_bit(d[i], hold);
        send_bit(pbit, hold);
        send_bit(stopb, hold);
    endtask

    task automatic wait_sb(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) idle(1);
        chk(tag, sb.size(), 32'd0);
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        sin    = 1'b1;
        repeat (3) tick();
        chk("rst_dout", {28'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_perr", {31'd0, parity_err}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        idle(3);

        // Good frame: 0,1,1,0,1,1,1 -> 4'hB, valid in cycle 8
        vcyc.delete();
        send_frame(4'hB, 1'b1, 1'b1, 1);
        wait_sb("good_timeout");
        chk("good_count", vcyc.size(), 32'd1);
        if (vcyc.size() > 0) chk("good_latency", vcyc[0] - start_cyc, 32'd8);
        chk("good_hold", {28'd0, dout}, 32'hB);

        // Parity error
        vcyc.delete();
        send_frame(4'hB, 1'b0, 1'b1, 1);
        wait_sb("perr_timeout");
        chk("perr_count", vcyc.size(), 32'd1);
        chk("perr_hold", {31'd0, parity_err}, 32'd1);

        // Framing error followed by a held-low break
        vcyc.delete();
        send_frame(4'h6, 1'b0, 1'b0, 1);
        repeat (5) send_bit(1'b0, 1);
        chk("brk_busy_low", {31'd0, busy}, 32'd1);
        chk("brk_count", vcyc.size(), 32'd1);
        chk("brk_ferr", {31'd0, frame_err}, 32'd1);
        chk("brk_sb_empty", sb.size(), 32'd0);
        idle(3);
        chk("brk_busy_idle", {31'd0, busy}, 32'd0);

        // Back-to-back frames, no idle gap
        vcyc.delete();
        s1 = cyc;
        send_frame(4'h5, 1'b0, 1'b1, 1);
        send_frame(4'hA, 1'b0, 1'b1, 1);
        wait_sb("b2b_timeout");
        chk("b2b_count", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) begin
            chk("b2b_first", vcyc[0] - s1, 32'd8);
            chk("b2b_gap", vcyc[1] - vcyc[0], 32'd7);
        end

        // Strobed rate: one strobe every 4 cycles
        vcyc.delete();
        send_frame(4'h3, 1'b0, 1'b1, 4);
        wait_sb("strobe_timeout");
        chk("strobe_count", vcyc.size(), 32'd1);
        chk("strobe_dout", {28'd0, dout}, 32'h3);

        // Reset after the 2nd data bit of a frame
        vcyc.delete();
        idle(2);
        send_bit(1'b0, 1);
        send_bit(1'b0, 1);
        send_bit(1'b0, 1);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_dout", {28'd0, dout}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_perr", {31'd0, parity_err}, 32'd0);
        chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        sin = 1'b1;
        tick();
        rst = 1'b0;
        idle(4);
        chk("mid_no_valid", vcyc.size(), 32'd0);
        send_frame(4'hC, 1'b0, 1'b1, 1);
        wait_sb("after_rst_timeout");
        chk("after_rst_count", vcyc.size(), 32'd1);
        chk("after_rst_dout", {28'd0, dout}, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
